// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer: FSM encodings and default width.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SERIAL_ADD_WIDTH = 8;

  // One spare bit so the counter never wraps, even at the widest operand.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell shared by the serial datapath.
module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  assign sum_out   = a_in ^ b_in ^ c_in;
  assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for a WIDTH-bit add, one bit per clock LSB first, through a single full_adder.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a, sh_b, sh_s, sh_s_nxt;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_co;
  logic             last;

  full_adder u_fa (
    .a_in      (sh_a[0]),
    .b_in      (sh_b[0]),
    .c_in      (cy),
    .sum_out   (fa_sum),
    .carry_out (fa_co)
  );

  // Result enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sh_s_nxt = fa_sum;
    end else begin : g_wn
      assign sh_s_nxt = {fa_sum, sh_s[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_s      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a  <= a_in;
            sh_b  <= b_in;
            cy    <= c_in;
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          cy   <= fa_co;
          sh_s <= sh_s_nxt;
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum_out   <= sh_s_nxt;
            carry_out <= fa_co;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit add using a single instance of the team's 1-bit full_adder cell, one bit per clock, LSB first. It provides a start/busy/done handshake, latches operands at start, and walks the bit-serial carry chain. It returns a registered WIDTH-bit sum and carry-out. It is the area-minimal alternative to a ripple-carry array and sits between a requesting master and the shared full_adder datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse/level; sampled only in IDLE.
a_in  input  WIDTH  operand A; latched when start is accepted.
b_in  input  WIDTH  operand B; latched when start is accepted.
c_in  input  1  carry-in; latched when start is accepted.
busy  output  1  high while the state is not IDLE.
done  output  1  single-cycle completion pulse.
sum_out  output  WIDTH  registered result; held until the next completion.
carry_out  output  1  registered final carry; held until the next completion.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is sampled high, the state goes to IDLE and every register clears: busy=0, done=0, sum_out=0, carry_out=0, shift registers, carry register and bit counter all 0.
- FSM states: IDLE, ADD, DONE. Encoding is local, 2 bits.
- IDLE:
  - If start=1, latch a_in, b_in and c_in into shift registers sh_a, sh_b and carry register cy.
  - Clear the bit counter cnt and go to ADD.
  - Otherwise stay in IDLE.
- ADD, each cycle:
  - The full_adder inputs are sh_a[0], sh_b[0] and cy.
  - cy <= carry output of the cell.
  - The result shift register shifts right with the cell's sum entering at bit WIDTH-1.
  - sh_a and sh_b shift right by one; cnt <= cnt+1.
  - When cnt==WIDTH-1, on that edge load sum_out with the final shifted result and carry_out with the cell carry, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- busy: combinational decode, busy = (state != IDLE), so it is high in ADD and DONE.
- Latency: start sampled at edge k → ADD occupies edges k+1..k+WIDTH → done=1 during the cycle after edge k+WIDTH, and sum_out/carry_out are valid in that same cycle. Total is WIDTH+1 cycles from acceptance to done.
- Throughput: one add per WIDTH+2 cycles if start is held high. The earliest re-acceptance is at the IDLE edge following DONE.
- start while busy (ADD or DONE) is ignored. No queuing; operand changes mid-operation have no effect.
- Arithmetic: {carry_out, sum_out} = a_in + b_in + c_in as a (WIDTH+1)-bit sum, using operands latched at acceptance. Wrap-around appears only as carry_out=1.
- Reset mid-operation aborts the add. No done pulse is issued, outputs clear, and a fresh start is accepted on the first non-reset IDLE cycle.
- Reset and start in the same cycle: reset wins.
- WIDTH=1: a single ADD cycle; done follows 2 cycles after acceptance.
- cnt width is $clog2(WIDTH)+1 bits, so there is no overflow at WIDTH=32.

Decomposition:
- Shared include/package: state localparams (S_IDLE=2'd0, S_ADD=2'd1, S_DONE=2'd2) and a default SERIAL_ADD_WIDTH constant, so the bench and top levels agree.
- Sub-module: exactly one instance of the existing full_adder (ports a_in, b_in, c_in, sum_out, carry_out), reused unchanged.
- FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, c_in=0, start pulse at edge 0 → busy=1 from cycle 1; done=1 only in cycle 9; sum_out=0x96, carry_out=0; busy=0 at cycle 10.
2. a=0xFF, b=0x01, c_in=0 → sum_out=0x00, carry_out=1; and a=0xFF, b=0xFF, c_in=1 → sum_out=0xFF, carry_out=1.
3. Accept a=0x12, b=0x34, then at cycle 3 drive start=1 with a=0xAA, b=0xAA → second request ignored; result 0x46, carry 0; exactly one done pulse.
4. Reset asserted for one cycle during the 4th ADD cycle → next cycle busy=0, done=0, sum_out=0, carry_out=0, and no done pulse. A following op 0x80+0x80+0 gives sum 0x00, carry 1.
5. start held high continuously with a=0x01, b=0x01 → done pulses at cycles 9, 19, 29 (period WIDTH+2), each with sum_out=0x02.
6. Randomised sweep of 200 operand sets at WIDTH=8 and WIDTH=1 → {carry_out, sum_out} equals a+b+c_in every time, and done always occurs exactly WIDTH+1 cycles after acceptance.
